// File: rtl/arc_mem_pkg.sv
// arc_mem_pkg: shared types and constants for the ARC memory access path.
//   mem_state_t       : controller FSM states
//   ERR_*             : 2-bit response error codes
//   DEFAULT_USER_BASE : first address writable from user mode
//   PROG_START_ADDR   : address where main_memory reloads the program image
package arc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_PROT  = 2'b10;

  localparam int DEFAULT_USER_BASE = 2048;
  localparam int PROG_START_ADDR   = 2048;

  // A word access must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/arc_mem_addr_chk.sv
// arc_mem_addr_chk: combinational access check, shared with the fetch path.
//   addr : byte address of the access
//   we   : 1 = store
//   sys  : 1 = system mode (write protection bypassed)
//   err  : ERR_OK, ERR_ALIGN or ERR_PROT
module arc_mem_addr_chk
  import arc_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int USER_BASE = DEFAULT_USER_BASE,
  parameter int ALIGN_CHK = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              sys,
  output logic [1:0]        err
);

  localparam logic [ADDR_W-1:0] USER_BASE_A = ADDR_W'(USER_BASE);

  // Misalignment takes priority over protection; the region compare is
  // unsigned across the full address width.
  always_comb begin
    err = ERR_OK;
    if ((ALIGN_CHK != 0) && is_misaligned(addr[1:0])) begin
      err = ERR_ALIGN;
    end else if (we && !sys && (addr < USER_BASE_A)) begin
      err = ERR_PROT;
    end
  end

endmodule

// File: rtl/arc_mem_ctrl.sv
// arc_mem_ctrl: single-outstanding load/store controller in front of
// main_memory.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_we, req_sys          : store flag, system-mode flag
//   req_addr, req_wdata      : byte address, store data
//   resp_valid               : one-cycle response pulse
//   resp_rdata, resp_err     : load data (0 for stores/errors), error code
//   mem_address, mem_data_in : to main_memory
//   mem_rd, mem_wr           : one-cycle strobes to main_memory
//   mem_data_out             : from main_memory, valid RD_LAT cycles after mem_rd
module arc_mem_ctrl
  import arc_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int USER_BASE = DEFAULT_USER_BASE,
  parameter int ALIGN_CHK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_sys,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  mem_state_t        state, state_d;
  logic [2:0]        cnt, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic [DATA_W-1:0] mem_data_in_d;
  logic              mem_rd_d, mem_wr_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_d;
  logic [1:0]        resp_err_d;
  logic [1:0]        chk_err;
  logic              accept;

  arc_mem_addr_chk #(
    .ADDR_W   (ADDR_W),
    .USER_BASE(USER_BASE),
    .ALIGN_CHK(ALIGN_CHK)
  ) u_addr_chk (
    .addr(req_addr),
    .we  (req_we),
    .sys (req_sys),
    .err (chk_err)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear one cycle later: the strobe decided on the
  // accept edge is visible during the ISSUE cycle, and the response decided
  // on the last ISSUE/WAIT edge is visible during the RESP cycle.
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    we_d          = we_q;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata;
    resp_err_d    = resp_err;

    case (state)
      IDLE: begin
        if (accept) begin
          if (chk_err != ERR_OK) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = chk_err;
            resp_rdata_d = '0;
          end else begin
            state_d       = ISSUE;
            we_d          = req_we;
            mem_address_d = req_addr;
            mem_rd_d      = !req_we;
            mem_wr_d      = req_we;
            if (req_we) begin
              mem_data_in_d = req_wdata;
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_OK;
          resp_rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ERR_OK;
          resp_rdata_d = mem_data_out;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, which drops any
  // in-flight strobe and discards a pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      we_q        <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= ERR_OK;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      we_q        <= we_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
      mem_rd      <= mem_rd_d;
      mem_wr      <= mem_wr_d;
      resp_valid  <= resp_valid_d;
      resp_rdata  <= resp_rdata_d;
      resp_err    <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_arc_mem_ctrl.sv
// tb_arc_mem_ctrl: scoreboard bench for arc_mem_ctrl with a main_memory
// stand-in (registered read of TB_RD_LAT cycles) and a reference model that
// predicts response timing, error codes and data from the access rules.
module tb_arc_mem_ctrl;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int TB_RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic              req_sys = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_out;

  arc_mem_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (TB_RD_LAT),
    .USER_BASE(2048),
    .ALIGN_CHK(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_sys     (req_sys),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [1:0]  err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  resp_t   exp_resp[$];
  strobe_t exp_strobe[$];
  resp_t   got_r;
  strobe_t got_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] ref_words [logic [31:0]];
  logic [31:0] rd_pipe [TB_RD_LAT];

  // Edge counter: at the falling edge after rising edge number E, cyc == E.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (ref_words.exists(a)) return ref_words[a];
    return 32'h0;
  endfunction

  // main_memory stand-in: writes land on the strobe edge; a read sampled on
  // the mem_rd edge ripples through TB_RD_LAT registers to mem_data_out.
  always @(posedge clk) begin
    if (mem_wr) mem_words[mem_address] = mem_data_in;
    if (mem_rd) rd_pipe[0] <= memRead(mem_address);
    for (int i = 1; i < TB_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[TB_RD_LAT-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Reference rules: alignment first, then user-mode writes below 2048.
  function automatic logic [1:0] expErr(input logic we, input logic sys, input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (we && !sys && (a < 32'd2048)) return 2'b10;
    return 2'b00;
  endfunction

  // Push what the accepted request must produce: a strobe right after the
  // accept edge, then the response after 0 (error), 1 (store) or
  // 1+RD_LAT (load) further edges.
  task automatic predict(input logic we, input logic sys, input logic [31:0] a,
                         input logic [31:0] d, input int acc);
    logic [1:0] e;
    e = expErr(we, sys, a);
    if (e != 2'b00) begin
      exp_resp.push_back('{cyc: acc, err: e, rdata: 32'h0});
    end else if (we) begin
      exp_strobe.push_back('{cyc: acc, we: 1'b1, addr: a, data: d});
      ref_words[a] = d;
      exp_resp.push_back('{cyc: acc + 1, err: 2'b00, rdata: 32'h0});
    end else begin
      exp_strobe.push_back('{cyc: acc, we: 1'b0, addr: a, data: 32'h0});
      exp_resp.push_back('{cyc: acc + 1 + TB_RD_LAT, err: 2'b00, rdata: refRead(a)});
    end
  endtask

  // Drive one request from a falling edge, wait (bounded) for acceptance,
  // and return the accept edge number. req_valid is left high.
  task automatic applyStimulus(input logic we, input logic sys, input logic [31:0] a,
                               input logic [31:0] d, output int acc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_sys   = sys;
    req_addr  = a;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      flagFail("accept_timeout", "req_ready never rose");
      acc = -1;
    end else begin
      acc = cyc + 1;
      predict(we, sys, a, d, acc);
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"},   32'(req_ready),  32'h0);
    checkOutput({tag, "_resp_valid"},  32'(resp_valid), 32'h0);
    checkOutput({tag, "_resp_rdata"},  resp_rdata,      32'h0);
    checkOutput({tag, "_resp_err"},    32'(resp_err),   32'h0);
    checkOutput({tag, "_mem_rd"},      32'(mem_rd),     32'h0);
    checkOutput({tag, "_mem_wr"},      32'(mem_wr),     32'h0);
    checkOutput({tag, "_mem_address"}, mem_address,     32'h0);
    checkOutput({tag, "_mem_data_in"}, mem_data_in,     32'h0);
  endtask

  // Monitor: every response and every strobe the DUT shows must match the
  // oldest prediction, including the edge on which it appears.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          flagFail("unexpected_resp", "resp_valid=1 with no pending request");
        end else begin
          got_r = exp_resp.pop_front();
          checkOutput("resp_cycle", 32'(cyc), 32'(got_r.cyc));
          checkOutput("resp_err", 32'(resp_err), 32'(got_r.err));
          checkOutput("resp_rdata", resp_rdata, got_r.rdata);
        end
      end
      if (mem_rd && mem_wr) flagFail("strobe_overlap", "mem_rd=1 and mem_wr=1");
      if (mem_rd || mem_wr) begin
        if (exp_strobe.size() == 0) begin
          flagFail("unexpected_strobe", "strobe with no pending memory access");
        end else begin
          got_s = exp_strobe.pop_front();
          checkOutput("strobe_cycle", 32'(cyc), 32'(got_s.cyc));
          checkOutput("strobe_kind", 32'(mem_wr), 32'(got_s.we));
          checkOutput("strobe_addr", mem_address, got_s.addr);
          if (got_s.we) checkOutput("strobe_wdata", mem_data_in, got_s.data);
        end
      end
    end
  end

  // Watchdog in case something upstream stalls forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a1, a2, acc, n, g;
    logic we, sys;
    logic [31:0] addr, data;

    for (int i = 0; i < TB_RD_LAT; i++) rd_pipe[i] = 32'h0;
    mem_words[32'd2048] = 32'hc2002844;
    mem_words[32'd2052] = 32'h82804002;
    mem_words[32'd2116] = 32'h00000001;
    ref_words[32'd2048] = 32'hc2002844;
    ref_words[32'd2052] = 32'h82804002;
    ref_words[32'd2116] = 32'h00000001;

    // Power-on reset.
    repeat (3) @(negedge clk);
    checkResetOutputs("por");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("por_ready_after", 32'(req_ready), 32'h1);

    // Directed accesses from the program image and the region boundary.
    applyStimulus(1'b0, 1'b0, 32'd2116, 32'h0, acc);
    applyStimulus(1'b1, 1'b0, 32'd2088, 32'h00000005, acc);
    applyStimulus(1'b0, 1'b0, 32'd2088, 32'h0, acc);
    applyStimulus(1'b1, 1'b0, 32'd20, 32'hdeadbeef, acc);
    applyStimulus(1'b1, 1'b1, 32'd20, 32'habcd1234, acc);
    applyStimulus(1'b0, 1'b0, 32'd20, 32'h0, acc);
    applyStimulus(1'b0, 1'b0, 32'd2050, 32'h0, acc);
    req_valid = 1'b0;

    // Reset during the WAIT phase of a load: the response must vanish.
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    applyStimulus(1'b0, 1'b0, 32'd2048, 32'h0, acc);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_resp.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetOutputs("midrst");
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready_after", 32'(req_ready), 32'h1);

    // Back-to-back loads with req_valid held high.
    applyStimulus(1'b0, 1'b0, 32'd2048, 32'h0, a1);
    applyStimulus(1'b0, 1'b0, 32'd2052, 32'h0, a2);
    req_valid = 1'b0;
    checkOutput("b2b_accept_gap", 32'(a2 - a1), 32'(TB_RD_LAT + 3));

    // Random traffic across user, system, boundary, misaligned and top
    // addresses.
    for (int k = 0; k < 80; k++) begin
      we  = 1'($urandom_range(0, 1));
      sys = ($urandom_range(0, 3) == 0);
      data = $urandom;
      case ($urandom_range(0, 4))
        0: addr = 32'd2048 + 32'(4 * $urandom_range(0, 31));
        1: addr = 32'(4 * $urandom_range(0, 15));
        2: addr = ($urandom_range(0, 1) == 0) ? 32'd2044 : 32'd2048;
        3: addr = 32'd2048 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
        default: addr = 32'hFFFF_FFFC - 32'(4 * $urandom_range(0, 3));
      endcase
      applyStimulus(we, sys, addr, data, acc);
      g = $urandom_range(0, 2);
      if (g != 0) begin
        req_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
    req_valid = 1'b0;

    // Drain outstanding predictions.
    n = 0;
    while ((exp_resp.size() != 0 || exp_strobe.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_resp.size() != 0 || exp_strobe.size() != 0)
      flagFail("drain_timeout", $sformatf("resp=%0d strobe=%0d still pending", exp_resp.size(), exp_strobe.size()));
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
